// File: rtl/md_sched.sv
// HI/LO multiply-divide unit: multi-cycle mult/div with a fixed busy period,
// single-cycle mthi/mtlo, combinational mfhi/mflo read-out and D-stage stall request.
module md_sched #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  input  logic [31:0] instr_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  output logic        busy,
  output logic        stall,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MTHI = 6'b010001;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_MTLO = 6'b010011;
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        div_q, div_d, sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        rtype_e, rtype_d;
  logic        e_start, e_mthi, e_mtlo, e_mfhi, e_mflo, d_md;
  logic [63:0] prod;
  logic [31:0] quot, rem;

  always_comb begin
    rtype_e = (instr_E[31:26] == 6'b000000);
    rtype_d = (instr_D[31:26] == 6'b000000);
    e_start = rtype_e && (instr_E[5:2] == 4'b0110);
    e_mfhi  = rtype_e && (instr_E[5:0] == FN_MFHI);
    e_mthi  = rtype_e && (instr_E[5:0] == FN_MTHI);
    e_mflo  = rtype_e && (instr_E[5:0] == FN_MFLO);
    e_mtlo  = rtype_e && (instr_E[5:0] == FN_MTLO);
    d_md    = rtype_d && ((instr_D[5:2] == 4'b0110) || (instr_D[5:2] == 4'b0100));
  end

  // Arithmetic works only on the latched operands, so E-stage inputs may change freely while busy.
  always_comb begin
    if (sgn_q)
      prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    else
      prod = {32'h0, a_q} * {32'h0, b_q};
    quot = '0;
    rem  = '0;
    if (b_q != 32'h0) begin
      if (sgn_q) begin
        quot = $signed(a_q) / $signed(b_q);
        rem  = $signed(a_q) % $signed(b_q);
      end else begin
        quot = a_q / b_q;
        rem  = a_q % b_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    div_d   = div_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (e_start) begin
          a_d     = rs_E;
          b_d     = rt_E;
          div_d   = instr_E[1];
          sgn_d   = ~instr_E[0];
          cnt_d   = instr_E[1] ? DIV_LOAD : MULT_LOAD;
          state_d = BUSY;
        end else if (e_mthi) begin
          hi_d = rs_E;
        end else if (e_mtlo) begin
          lo_d = rs_E;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          if (!div_q) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != 32'h0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      div_q   <= div_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    busy   = (state_q == BUSY);
    stall  = d_md && ((state_q == BUSY) || e_start);
    hi     = hi_q;
    lo     = lo_q;
    md_out = e_mfhi ? hi_q : (e_mflo ? lo_q : 32'h0);
  end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: HI/LO arithmetic, busy length, stall, mt/mf and reset abort.
module tb_md_sched;

  localparam logic [31:0] I_NOP   = 32'h0000_0000;
  localparam logic [31:0] I_MULT  = 32'h0000_0018;
  localparam logic [31:0] I_MULTU = 32'h0000_0019;
  localparam logic [31:0] I_DIV   = 32'h0000_001A;
  localparam logic [31:0] I_DIVU  = 32'h0000_001B;
  localparam logic [31:0] I_MFHI  = 32'h0000_0010;
  localparam logic [31:0] I_MTHI  = 32'h0000_0011;
  localparam logic [31:0] I_MFLO  = 32'h0000_0012;
  localparam logic [31:0] I_MTLO  = 32'h0000_0013;
  localparam logic [31:0] I_ADDU  = 32'h0085_1021;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_D, instr_E, rs_E, rt_E;
  logic        busy, stall;
  logic [31:0] md_out, hi, lo;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  md_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .instr_D(instr_D),
    .instr_E(instr_E),
    .rs_E   (rs_E),
    .rt_E   (rt_E),
    .busy   (busy),
    .stall  (stall),
    .md_out (md_out),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start op in E, hold busy_instr in E during the busy period, check busy/stall every cycle.
  task automatic run_op(input string tag, input logic [31:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned ncyc,
                        input logic [31:0] busy_instr, input logic d_md);
    instr_E = op;
    rs_E    = a;
    rt_E    = b;
    #1;
    check({tag, "_stall_start"}, {31'b0, stall}, {31'b0, d_md});
    step();
    instr_E = busy_instr;
    rs_E    = 32'hDEAD_BEEF;
    rt_E    = 32'h0000_0001;
    for (int i = 0; i < int'(ncyc); i++) begin
      #1;
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      check({tag, "_stall_busy"}, {31'b0, stall}, {31'b0, d_md});
      step();
    end
    instr_E = I_NOP;
    #1;
    check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset   = 1'b0;
    instr_D = I_NOP;
    instr_E = I_NOP;
    rs_E    = '0;
    rt_E    = '0;
    step();
    step();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    reset = 1'b1;
    step();

    // mult -2*3 with mflo in D; illegal div in E while busy must be ignored
    instr_D = I_MFLO;
    run_op("mult", I_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 5, I_DIV, 1'b1);
    check("mult_stall_idle", {31'b0, stall}, 32'd0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    instr_E = I_MFLO;
    #1;
    check("mult_mflo", md_out, 32'hFFFF_FFFA);
    check("mult_stall_mflo", {31'b0, stall}, 32'd0);
    instr_E = I_MFHI;
    #1;
    check("mult_mfhi", md_out, 32'hFFFF_FFFF);
    step();

    instr_D = I_NOP;
    run_op("multu", I_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, I_MTHI, 1'b0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    instr_D = I_ADDU;
    run_op("div", I_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 10, I_MTLO, 1'b0);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    instr_D = I_NOP;
    run_op("divu0", I_DIVU, 32'h0000_0007, 32'h0000_0000, 10, I_NOP, 1'b0);
    check("divu0_hi", hi, 32'hFFFF_FFFF);
    check("divu0_lo", lo, 32'hFFFF_FFFD);

    instr_E = I_MTHI;
    rs_E    = 32'h1234_5678;
    step();
    check("mthi_busy", {31'b0, busy}, 32'd0);
    instr_E = I_MFHI;
    #1;
    check("mthi_mfhi", md_out, 32'h1234_5678);
    instr_E = I_MTLO;
    rs_E    = 32'hCAFE_F00D;
    step();
    instr_E = I_MFLO;
    #1;
    check("mtlo_mflo", md_out, 32'hCAFE_F00D);
    check("mtlo_hi_kept", hi, 32'h1234_5678);

    instr_E = I_ADDU;
    rs_E    = 32'h0000_0055;
    step();
    instr_E = I_NOP;
    #1;
    check("addu_hi", hi, 32'h1234_5678);
    check("addu_lo", lo, 32'hCAFE_F00D);
    check("nop_md_out", md_out, 32'h0);

    // abort a div at cnt==3 (seven edges after start)
    instr_E = I_DIV;
    rs_E    = 32'd100;
    rt_E    = 32'd7;
    step();
    instr_E = I_NOP;
    for (int i = 0; i < 6; i++) step();
    check("abort_busy_pre", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    instr_D = I_MFLO;
    instr_E = I_MULT;
    #1;
    check("abort_stall_rst", {31'b0, stall}, 32'd1);
    instr_E = I_MFHI;
    #1;
    check("abort_mdout_rst", md_out, 32'h0);
    reset   = 1'b1;
    instr_D = I_NOP;
    run_op("post_rst", I_MULT, 32'd7, 32'd6, 5, I_NOP, 1'b0);
    check("post_rst_hi", hi, 32'h0);
    check("post_rst_lo", lo, 32'h0000_002A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 The block SHALL have parameter MULT_CYC, default 5, meaning busy cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYC, default 10, meaning busy cycles for div/divu.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port instr_D  input  32  instruction in the D stage, used for stall detection.
REQ-006 The block SHALL have port instr_E  input  32  instruction in the E stage, used to start, write or read the HI/LO unit.
REQ-007 The block SHALL have port rs_E  input  32  forwarded rs operand of instr_E.
REQ-008 The block SHALL have port rt_E  input  32  forwarded rt operand of instr_E.
REQ-009 The block SHALL have port busy  output  1  a multi-cycle operation is in progress.
REQ-010 The block SHALL have port stall  output  1  D-stage hold request to the hazard unit.
REQ-011 The block SHALL have port md_out  output  32  HI for mfhi, LO for mflo, else 0.
REQ-012 The block SHALL have ports hi and lo  output  32 each  architectural HI/LO register values.

Function
REQ-013 Decode SHALL use op==000000 and funct: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011; these eight are "md-class".
REQ-014 The FSM SHALL have states IDLE and BUSY plus a 4-bit down-counter cnt.
REQ-015 In IDLE, when instr_E is mult/multu/div/divu: operands, operation and signedness SHALL be latched at the edge, cnt SHALL load MULT_CYC-1 or DIV_CYC-1, and the state SHALL go to BUSY.
REQ-016 In BUSY, cnt SHALL decrement each edge; on the edge where cnt==0, HI/LO SHALL be written and the state SHALL return to IDLE.
REQ-017 busy SHALL be 1 exactly in BUSY, so it is high for MULT_CYC (5) or DIV_CYC (10) cycles following the start edge.
REQ-018 mult SHALL produce the signed 64-bit product, with {hi,lo} = product; multu SHALL do the same unsigned.
REQ-019 div SHALL produce signed results (lo=quotient truncated toward zero, hi=remainder with the sign of the dividend); divu SHALL produce unsigned results.
REQ-020 For div/divu with latched rt==0, HI and LO SHALL be left unchanged, while the full DIV_CYC busy period SHALL still be taken.
REQ-021 In IDLE, mthi/mtlo in E SHALL write rs_E to hi/lo at the edge, single cycle, with no busy.
REQ-022 md_out SHALL be combinational: hi when instr_E is mfhi, lo when instr_E is mflo, else 32'h0.
REQ-023 stall SHALL equal (instr_D md-class) AND (busy OR instr_E is mult/multu/div/divu).
REQ-024 Any md-class instruction in E while BUSY (illegal given REQ-023) SHALL be ignored: no state, counter or HI/LO change.
REQ-025 The end-of-operation write and a new start in the same cycle SHALL NOT occur; a start is only accepted in IDLE.
REQ-026 Non-md-class instructions, including nop (0x00000000), SHALL have no effect.

Reset
REQ-027 When reset==0, asynchronously: state=IDLE, cnt=0, hi=0, lo=0, and latched operands cleared, giving busy=0.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no HI/LO write; on release the block SHALL be IDLE and accept a start on the first edge.
REQ-029 stall and md_out SHALL follow the combinational rules during reset, with busy=0 and hi=lo=0.

Verification
REQ-030 Scenario: mult rs=0xFFFFFFFE(-2), rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF and lo=0xFFFFFFFA.
REQ-031 Scenario: multu 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE and lo=0x00000001 after 5 busy cycles.
REQ-032 Scenario: div -7/2 -> lo=0xFFFFFFFD and hi=0xFFFFFFFF after 10 busy cycles; divu 7/0 -> hi/lo unchanged after 10 busy cycles.
REQ-033 Scenario: instr_E=mult, instr_D=mflo -> stall=1 on the start cycle and through all busy cycles, and 0 on the first IDLE cycle, when md_out=new lo.
REQ-034 Scenario: mthi rs=0x12345678, then mfhi next cycle -> md_out=0x12345678; instr_D=addu while busy -> stall=0.
REQ-035 Scenario: reset pulled low at cnt==3 of a div -> busy=0 and hi=lo=0 immediately; after release, a mult completes normally.
